// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: circular byte FIFO in front of a UART transmitter.
// Pops one byte per transmitter cycle, issuing a registered one-cycle
// tx_start launch pulse and holding tx_data until the next launch.
// Writes into a full FIFO are dropped and latch a sticky overflow flag.
module uart_tx_buffer #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              tx_done_tick,
    input  logic              ovf_clr,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DBIT-1:0]     mem [0:DEPTH-1];
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   wr_ptr;
    logic                pop;
    logic                wr_acc;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    // the write that coincides with a launch.
    assign wr_acc = wr_en && (!full || pop);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a launch happens only from IDLE with stored data
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (tx_done_tick) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointers, occupancy, launch registers and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            tx_start <= pop;
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed and randomized checks of uart_tx_buffer
// against a queue-based reference model of the buffer and transmitter.
module tb_uart_tx_buffer;

    localparam int DBIT   = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [DBIT-1:0]   wr_data;
    logic              tx_done_tick;
    logic              ovf_clr;
    logic              tx_start;
    logic [DBIT-1:0]   tx_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;

    uart_tx_buffer #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .tx_done_tick (tx_done_tick),
        .ovf_clr      (ovf_clr),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DBIT-1:0] q[$];
    logic [DBIT-1:0] m_data;
    bit              m_start;
    bit              m_busy;
    bit              m_ovf;

    // bench-side transmitter
    int tx_timer;
    int tx_delay;
    bit tx_hold;
    bit stray;
    bit rand_delay;

    // launches observed on the DUT
    int              dut_launches;
    logic [DBIT-1:0] dut_log[$];
    logic [DBIT-1:0] exp_log[$];
    int              max_cnt;
    int              base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_data  = '0;
        m_start = 1'b0;
        m_busy  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        bit pop_m;
        bit acc;
        pop_m   = !m_busy && (q.size() != 0);
        acc     = wr_en && ((q.size() < DEPTH) || pop_m);
        m_start = 1'b0;
        if (pop_m) begin
            m_data  = q.pop_front();
            m_start = 1'b1;
            m_busy  = 1'b1;
        end else if (m_busy && tx_done_tick) begin
            m_busy = 1'b0;
        end
        if (acc) q.push_back(wr_data);
        if (wr_en && !acc) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".tx_start"}, 32'(tx_start), 32'(m_start));
        check({tag, ".tx_data"},  32'(tx_data),  32'(m_data));
        check({tag, ".count"},    32'(count),    32'(q.size()));
        check({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        check({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step();
        if (m_busy) begin
            if (!tx_hold && tx_timer > 0) tx_timer--;
            tx_done_tick = !tx_hold && (tx_timer == 0);
        end else begin
            tx_done_tick = stray && ($urandom_range(0, 5) == 0);
        end
        @(posedge clk);
        model_edge();
        if (m_start) tx_timer = rand_delay ? int'($urandom_range(1, 6)) : tx_delay;
        #1;
        check_outputs("step");
        if (tx_start === 1'b1) begin
            dut_launches++;
            dut_log.push_back(tx_data);
        end
        if (int'(count) > max_cnt) max_cnt = int'(count);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_data = '0; tx_done_tick = 1'b0; ovf_clr = 1'b0;
        tx_timer = 0; tx_delay = 10; tx_hold = 1'b0; stray = 1'b0; rand_delay = 1'b0;
        dut_launches = 0; max_cnt = 0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // single byte: launch two edges after the write
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("single.count1", 32'(count), 32'd1);
        check("single.no_start", 32'(tx_start), 32'd0);
        step();
        check("single.start", 32'(tx_start), 32'd1);
        check("single.data", 32'(tx_data), 32'hA5);
        check("single.count0", 32'(count), 32'd0);
        repeat (12) step();

        // burst 0x01..0x05 with 10-cycle transmitter
        dut_log.delete();
        base = dut_launches;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        repeat (70) step();
        check("burst.launches", 32'(dut_launches - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < dut_log.size()) check("burst.order", 32'(dut_log[i]), 32'(i + 1));
            else check("burst.missing", 32'(dut_log.size()), 32'd5);
        end

        // overflow with transmitter held busy
        tx_hold = 1'b1;
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        step();
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        check("ovf.count", 32'(count), 32'(DEPTH));
        check("ovf.full", 32'(full), 32'd1);
        check("ovf.flag", 32'(overflow), 32'd1);
        wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 8'h11;
        step();
        check("ovf.set_priority", 32'(overflow), 32'd1);
        wr_en = 1'b0;
        step();
        ovf_clr = 1'b0;
        check("ovf.clear", 32'(overflow), 32'd0);

        // full FIFO with a pop in the same cycle as a write
        tx_hold = 1'b0; tx_timer = 1; tx_delay = 3;
        step();
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        check("fullpop.start", 32'(tx_start), 32'd1);
        check("fullpop.count", 32'(count), 32'(DEPTH));
        check("fullpop.ovf", 32'(overflow), 32'd0);
        repeat (100) step();
        check("fullpop.drained", 32'(count), 32'd0);

        // pointer wrap: 3*DEPTH bytes paced so the FIFO never fills
        tx_delay = 2; max_cnt = 0;
        dut_log.delete(); exp_log.delete();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            exp_log.push_back(wr_data);
            step();
            wr_en = 1'b0;
            step();
            step();
        end
        repeat (20) step();
        check("wrap.never_full", 32'(max_cnt < DEPTH), 32'd1);
        check("wrap.size", 32'(dut_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++)
            check("wrap.seq", 32'(dut_log[i]), 32'(exp_log[i]));

        // randomized traffic with stray ticks and random transmitter timing
        stray = 1'b1; rand_delay = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        wr_en = 1'b0; ovf_clr = 1'b0; stray = 1'b0; rand_delay = 1'b0;
        tx_delay = 1;
        repeat (60) step();

        // reset with count=7 while BUSY
        tx_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            step();
        end
        wr_en = 1'b0;
        check("rst.count7", 32'(count), 32'd7);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        tx_timer = 0; tx_hold = 1'b0;
        check_outputs("rst.async");
        @(negedge clk);
        reset = 1'b1;
        base = dut_launches;
        repeat (10) step();
        check("rst.no_launch", 32'(dut_launches - base), 32'd0);
        wr_en = 1'b1; wr_data = 8'h3C;
        step();
        wr_en = 1'b0;
        step();
        check("rst.new_start", 32'(tx_start), 32'd1);
        check("rst.new_data", 32'(tx_data), 32'h3C);
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 SHALL have parameter DBIT, default 8, byte width stored and presented to the transmitter.
REQ-002 SHALL have parameter ADDR_W, default 4, FIFO address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write strobe, one byte per asserted cycle.
REQ-006 SHALL have port wr_data  input  DBIT  byte to enqueue.
REQ-007 SHALL have port tx_done_tick  input  1  one-cycle pulse from transmitter at end of stop bit.
REQ-008 SHALL have port ovf_clr  input  1  clears sticky overflow flag.
REQ-009 SHALL have port tx_start  output  1  registered one-cycle launch pulse to transmitter.
REQ-010 SHALL have port tx_data  output  DBIT  registered byte for transmitter, valid in tx_start cycle and held until next launch.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port count  output  ADDR_W+1  occupied entries, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky flag, set on dropped write.

Function
REQ-015 SHALL store bytes in a DEPTH-entry circular FIFO with ADDR_W-bit rd/wr pointers wrapping DEPTH-1 -> 0.
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 IDLE, count>0: SHALL at the clock edge load tx_data<=mem[rd_ptr], set tx_start<=1, increment rd_ptr, decrement count, go BUSY.
REQ-018 IDLE, count==0: SHALL stay IDLE, tx_start<=0.
REQ-019 BUSY: SHALL drive tx_start<=0 (pulse exactly one cycle wide) and hold tx_data.
REQ-020 BUSY with tx_done_tick=1: SHALL go IDLE; next launch no earlier than the following edge.
REQ-021 tx_done_tick in IDLE SHALL be ignored.
REQ-022 Latency: byte written into empty FIFO in IDLE at edge N SHALL appear as tx_start=1 in the cycle after edge N+1.
REQ-023 Write SHALL be accepted when wr_en=1 and (count<DEPTH or a pop occurs in the same cycle); mem[wr_ptr]<=wr_data, wr_ptr++.
REQ-024 Simultaneous accepted write and pop SHALL leave count unchanged.
REQ-025 Write with wr_en=1, count==DEPTH and no pop SHALL be dropped, leave FIFO unchanged and set overflow<=1.
REQ-026 overflow SHALL remain 1 until ovf_clr=1; set has priority over clear in the same cycle.
REQ-027 Write into empty FIFO SHALL not be popped in the same cycle (count used is the registered value).
REQ-028 full, empty SHALL be combinational decodes of registered count.
REQ-029 Bytes SHALL be launched in write order; none lost or duplicated except per REQ-025.

Reset
REQ-030 reset=0 SHALL asynchronously force state IDLE, rd_ptr=0, wr_ptr=0, count=0, tx_start=0, tx_data=0, overflow=0.
REQ-031 After reset: empty=1, full=0; FIFO memory contents need not be reset.
REQ-032 Reset mid-transfer SHALL discard all queued bytes and the in-flight launch; no tx_start until new data written after release.

Verification
REQ-033 Single byte: write 0xA5 in IDLE -> tx_start one cycle two edges later, tx_data=0xA5, count 1->0, state BUSY until tx_done_tick.
REQ-034 Burst: write 0x01..0x05 back-to-back, model tx_done_tick 10 cycles after each tx_start -> five launches in order 0x01..0x05, exactly one tx_start per tx_done_tick.
REQ-035 Overflow: hold transmitter busy, write DEPTH+2 bytes -> count=DEPTH, full=1, overflow=1, last two dropped; ovf_clr -> overflow=0.
REQ-036 Full with pop: count=DEPTH, IDLE, wr_en=1 same cycle as launch -> write accepted, count stays DEPTH, overflow stays 0.
REQ-037 Wrap: 3*DEPTH bytes streamed with FIFO never full -> sequence intact across pointer wrap.
REQ-038 Reset mid-burst: assert reset with count=7 in BUSY -> count=0, tx_start=0, no launch after release until a new write.
